// File: rtl/fpu_mant_adder.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mant_adder
// Purpose  : Multi-cycle 24-bit mantissa adder with a registered ripple carry
//            and a 4-phase valid/ack handshake. Optional macro
//            FPU_MANT_ADD_SINGLE_CYCLE_EN performs the full add in one step.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mant_adder #(
    parameter int CHUNK = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Adder_datain1,
    input  logic [23:0] Adder_datain2,
    input  logic        Adder_valid,
    output logic [23:0] Adder_dataout,
    output logic        Adder_carryout,
    output logic [1:0]  Adder_Exc,
    output logic        Adder_ack
);

`ifdef FPU_MANT_ADD_SINGLE_CYCLE_EN
    localparam int c_CW     = 24;
`else
    localparam int c_CW     = CHUNK;
`endif
    localparam int c_NCHUNK = 24 / c_CW;
    localparam logic [4:0] c_LAST = 5'(c_NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [23:0]   r_op1;
    logic [23:0]   r_op2;
    logic [23:0]   r_sum;
    logic          r_carry;
    logic [4:0]    r_cnt;
    logic          r_err;
    logic [23:0]   r_dataout;
    logic          r_carryout;
    logic [1:0]    r_exc;
    logic          r_ack;

    logic          w_latch;
    logic          w_step;
    logic          w_last;
    logic          w_ack_clr;
    logic [4:0]    w_base;
    logic [c_CW:0] w_slice;
    logic [23:0]   w_sum_next;
    logic          w_err_next;

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a low valid in BUSY aborts without an ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Adder_valid) w_state_next = S_BUSY;
            S_BUSY: begin
                if (!Adder_valid)  w_state_next = S_IDLE;
                else if (w_last)   w_state_next = S_DONE;
            end
            S_DONE:  if (!Adder_valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control strobes and the per-chunk slice adder
    always_comb begin
        w_latch    = (r_state == S_IDLE) && Adder_valid;
        w_step     = (r_state == S_BUSY) && Adder_valid;
        w_ack_clr  = (r_state == S_DONE) && !Adder_valid;
        w_last     = (r_cnt == c_LAST);
        w_base     = 5'(r_cnt * c_CW);
        w_slice    = {1'b0, r_op1[w_base +: c_CW]}
                   + {1'b0, r_op2[w_base +: c_CW]}
                   + {{c_CW{1'b0}}, r_carry};
        w_sum_next = r_sum;
        w_sum_next[w_base +: c_CW] = w_slice[c_CW-1:0];
        w_err_next = r_err | (Adder_datain1 != r_op1) | (Adder_datain2 != r_op2);
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_op1      <= 24'd0;
            r_op2      <= 24'd0;
            r_sum      <= 24'd0;
            r_carry    <= 1'b0;
            r_cnt      <= 5'd0;
            r_err      <= 1'b0;
            r_dataout  <= 24'd0;
            r_carryout <= 1'b0;
            r_exc      <= 2'b00;
            r_ack      <= 1'b0;
        end else begin
            if (w_latch) begin
                r_op1   <= Adder_datain1;
                r_op2   <= Adder_datain2;
                r_carry <= 1'b0;
                r_cnt   <= 5'd0;
                r_err   <= 1'b0;
            end
            if (w_step) begin
                r_sum   <= w_sum_next;
                r_carry <= w_slice[c_CW];
                r_cnt   <= r_cnt + 5'd1;
                r_err   <= w_err_next;
                if (w_last) begin
                    r_dataout  <= w_sum_next;
                    r_carryout <= w_slice[c_CW];
                    r_exc      <= {1'b0, w_err_next};
                    r_ack      <= 1'b1;
                end
            end
            if (w_ack_clr) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign Adder_dataout  = r_dataout;
    assign Adder_carryout = r_carryout;
    assign Adder_Exc      = r_exc;
    assign Adder_ack      = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_fpu_mant_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mant_adder
// Purpose  : Directed, table-driven bench for fpu_mant_adder (CHUNK=4, or the
//            single-cycle build when FPU_MANT_ADD_SINGLE_CYCLE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mant_adder;

`ifdef FPU_MANT_ADD_SINGLE_CYCLE_EN
    localparam int c_LAT   = 2;
    localparam int c_CHG   = 1;
    localparam int c_ABORT = 1;
    localparam int c_MID   = 1;
`else
    localparam int c_LAT   = 7;
    localparam int c_CHG   = 3;
    localparam int c_ABORT = 2;
    localparam int c_MID   = 3;
`endif

    logic        CLK;
    logic        RSTn;
    logic [23:0] d1, d2;
    logic        valid;
    logic [23:0] dout;
    logic        cout;
    logic [1:0]  exc;
    logic        ack;

    int n_cmp = 0;
    int n_err = 0;

    fpu_mant_adder #(.CHUNK(4)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Adder_datain1  (d1),
        .Adder_datain2  (d2),
        .Adder_valid    (valid),
        .Adder_dataout  (dout),
        .Adder_carryout (cout),
        .Adder_Exc      (exc),
        .Adder_ack      (ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] sum;
        logic        co;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (n < 30) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (ack) break;
        end
    endtask

    task automatic drop_valid();
        @(negedge CLK);
        valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("ack_drop", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        logic seen;

        vecs[0] = '{24'h123456, 24'h111111, 24'h234567, 1'b0};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 24'h000000, 1'b1};
        vecs[2] = '{24'h800000, 24'h800000, 24'h000000, 1'b1};
        vecs[3] = '{24'hC00000, 24'hC00000, 24'h800000, 1'b1};
        vecs[4] = '{24'h0F0F0F, 24'hF0F0F0, 24'hFFFFFF, 1'b0};
        vecs[5] = '{24'hABCDEF, 24'h123456, 24'hBE0245, 1'b0};
        vecs[6] = '{24'h7FFFFF, 24'h000001, 24'h800000, 1'b0};

        RSTn  = 1'b0;
        valid = 1'b0;
        d1    = 24'd0;
        d2    = 24'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dout", {8'd0, dout}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_exc",  {30'd0, exc}, 32'd0);
        chk("rst_ack",  {31'd0, ack}, 32'd0);
        RSTn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge CLK); #1;
            d1 = vecs[i].a; d2 = vecs[i].b; valid = 1'b1;
            wait_ack(n);
            chk("latency", n, c_LAT);
            chk("dout",  {8'd0, dout}, {8'd0, vecs[i].sum});
            chk("cout",  {31'd0, cout}, {31'd0, vecs[i].co});
            chk("exc",   {30'd0, exc}, 32'd0);
            @(posedge CLK);
            @(negedge CLK);
            chk("ack_hold", {31'd0, ack}, 32'd1);
            drop_valid();
        end

        // Operand 2 changes mid-operation: result from latched value, Exc=01
        @(posedge CLK); #1;
        d1 = 24'h100000; d2 = 24'h000001; valid = 1'b1;
        repeat (c_CHG) @(posedge CLK);
        #1 d2 = 24'h000002;
        wait_ack(n);
        chk("stab_latency", n + c_CHG, c_LAT);
        chk("stab_dout", {8'd0, dout}, 32'h00100001);
        chk("stab_cout", {31'd0, cout}, 32'd0);
        chk("stab_exc",  {30'd0, exc}, 32'd1);
        drop_valid();

        // Abort in BUSY: no ack, outputs keep the previous result
        @(posedge CLK); #1;
        d1 = 24'h111111; d2 = 24'h222222; valid = 1'b1;
        repeat (c_ABORT) @(posedge CLK);
        #1 valid = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (ack) seen = 1'b1;
        end
        chk("abort_noack", {31'd0, seen}, 32'd0);
        chk("abort_dout", {8'd0, dout}, 32'h00100001);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_exc",  {30'd0, exc}, 32'd1);

        // Normal request after the abort
        @(posedge CLK); #1;
        d1 = 24'h123456; d2 = 24'h111111; valid = 1'b1;
        wait_ack(n);
        chk("post_latency", n, c_LAT);
        chk("post_dout", {8'd0, dout}, 32'h00234567);
        chk("post_exc",  {30'd0, exc}, 32'd0);
        drop_valid();

        // Reset pulse mid-BUSY clears everything, no ack follows
        @(posedge CLK); #1;
        d1 = 24'h333333; d2 = 24'h444444; valid = 1'b1;
        repeat (c_MID) @(posedge CLK);
        #1 RSTn = 1'b0; valid = 1'b0;
        #2;
        chk("mrst_dout", {8'd0, dout}, 32'd0);
        chk("mrst_cout", {31'd0, cout}, 32'd0);
        chk("mrst_exc",  {30'd0, exc}, 32'd0);
        chk("mrst_ack",  {31'd0, ack}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (ack) seen = 1'b1;
        end
        chk("mrst_noack", {31'd0, seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
